matrix_input_collector: RTL and testbench
=========================================

Name: matrix_input_collector

Overview:
- Upstream stage of the 5x5 matrix datapath. Accepts a dimension pair, then r*c scalar elements one per valid/ready handshake.
- Packs the elements row-major into a fixed 25-slot, stride-5 matrix image. Slot k = row*5 + col; unused slots read as 0.
- Holds the packed matrix and dimensions stable with a level `done` flag. That flag is suitable for driving the enable of the transpose/arithmetic stages directly.

Parameters:
- DATA_WIDTH, 9, bit width of one matrix element.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request to begin collecting a matrix; sampled only in IDLE.
- dim_r  input  3  row count for this matrix; sampled with start.
- dim_c  input  3  column count for this matrix; sampled with start.
- elem_valid  input  1  elem_data holds a valid element.
- elem_data  input  DATA_WIDTH  element value.
- elem_ready  output  1  collector accepts an element this cycle.
- abort  input  1  cancel the collection in progress.
- clear  input  1  release a completed matrix and return to IDLE.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE; matrix outputs are valid and frozen.
- err_dim  output  1  one-cycle pulse when start is rejected for bad dimensions.
- r_out  output  3  latched row count.
- c_out  output  3  latched column count.
- elem_cnt  output  5  number of elements accepted so far (0..25).
- mat_flat  output  25*DATA_WIDTH  packed matrix; slot k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - All outputs 0: elem_ready, busy, done, err_dim, r_out, c_out, elem_cnt, mat_flat.
- State machine: IDLE -> LOAD -> DONE -> IDLE.
- IDLE:
  - elem_ready=0.
  - If start=1 and dim_r and dim_c are both in 1..5: latch r_out=dim_r, c_out=dim_c; zero all 25 slots; row=col=0; elem_cnt=0; go to LOAD next cycle.
  - If start=1 and either dimension is 0, 6 or 7: err_dim=1 for exactly the next cycle; stay in IDLE; r_out, c_out and mat_flat unchanged.
- LOAD:
  - elem_ready=1 combinationally while in LOAD. An element is accepted on any edge where elem_valid && elem_ready.
  - On accept:
    - write slot row*5+col with elem_data;
    - elem_cnt increments;
    - if col==c_out-1 then col=0 and row increments, else col increments.
  - When the accepted element is number r_out*c_out, go to DONE. done=1 and elem_ready=0 from the cycle after that accept. Load latency is one cycle per element, no bubbles required.
  - elem_valid low: no change, and the producer may hold any pause length.
  - start is ignored in LOAD.
- DONE:
  - done=1, busy=0.
  - mat_flat, r_out, c_out and elem_cnt are held constant regardless of elem_valid or start.
  - clear=1: go to IDLE next cycle. done drops; mat_flat and dims are retained until the next accepted start.
- abort:
  - In LOAD: go to IDLE next cycle; mat_flat zeroed; elem_cnt=0; any element presented on the same edge is discarded.
  - In IDLE or DONE: no effect.
- Simultaneous events:
  - abort has priority over an accept.
  - clear and start on the same cycle in DONE: clear only; start must be reissued in IDLE.
- Slot indexing is fixed stride 5 independent of c_out; e.g. element (1,0) of a 2x3 matrix lands in slot 5, not 3.
- Index arithmetic is 3-bit row/col and a 5-bit slot index. The row*5+col product is ≤24 and never wraps.
- Reset mid-LOAD: immediate return to reset values; the partial matrix is lost.

Decomposition:
- Shared package:
  - state encoding constants (IDLE/LOAD/DONE);
  - MAX_DIM=5, SLOTS=25, slot index width 5;
  - the dimension-valid check (1..MAX_DIM), which the transpose and other matrix stages reuse.
- One natural sub-module: matrix_slot_bank.
  - 25 x DATA_WIDTH register file with synchronous write enable, 5-bit write address, synchronous clear-all and flat read bus.
  - The FSM and counters remain in the top.

Test Plan:
- Reset then start with dim_r=2, dim_c=3; stream 1,2,3,4,5,6 back-to-back -> slots 0,1,2,5,6,7 = 1..6, all other slots 0; done=1 exactly one cycle after the 6th accept; r_out=2, c_out=3; elem_cnt=6.
- 5x5 load of values 0..24 with elem_valid deasserted for 3 cycles after element 10 -> slot k = k; no element lost or duplicated; elem_ready stays 1 during the gap; done only after the 25th accept.
- start with dim_r=0, dim_c=3, then start with dim_r=6, dim_c=2 -> err_dim single-cycle pulse each time; state stays IDLE; busy=0; outputs unchanged.
- 3x3 load aborted after 4 elements, with elem_valid=1 on the abort edge -> IDLE next cycle; mat_flat all 0; elem_cnt=0; the 5th element is not written.
- In DONE, drive elem_valid with 0x1FF and pulse start -> mat_flat unchanged; then clear -> done=0 next cycle and mat_flat retained; a new 1x1 start of 7 -> slot 0=7, all others 0.
- Assert rst_n low asynchronously mid-LOAD (between clock edges) -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/matrix_input_collector_pkg.sv
// Shared definitions for the 5x5 matrix datapath: state codes, geometry and
// the dimension check reused by the downstream matrix stages.
package matrix_input_collector_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned SLOTS   = 25;
    localparam int unsigned SLOT_W  = 5;

    function automatic logic dim_ok(input logic [2:0] d);
        return (d != 3'd0) && (32'(d) <= MAX_DIM);
    endfunction

endpackage

// File: rtl/matrix_input_collector_if.sv
// Control, element-stream and matrix-result bundle of the input collector.
interface matrix_input_collector_if #(parameter int unsigned DATA_WIDTH = 9);

    logic                     start;
    logic [2:0]               dim_r;
    logic [2:0]               dim_c;
    logic                     elem_valid;
    logic [DATA_WIDTH-1:0]    elem_data;
    logic                     elem_ready;
    logic                     abort;
    logic                     clear;
    logic                     busy;
    logic                     done;
    logic                     err_dim;
    logic [2:0]               r_out;
    logic [2:0]               c_out;
    logic [4:0]               elem_cnt;
    logic [25*DATA_WIDTH-1:0] mat_flat;

    modport master (
        output start, dim_r, dim_c, elem_valid, elem_data, abort, clear,
        input  elem_ready, busy, done, err_dim, r_out, c_out, elem_cnt, mat_flat
    );

    modport slave (
        input  start, dim_r, dim_c, elem_valid, elem_data, abort, clear,
        output elem_ready, busy, done, err_dim, r_out, c_out, elem_cnt, mat_flat
    );

endinterface

// File: rtl/matrix_slot_bank.sv
// 25-slot element register file: one synchronous write port, synchronous
// clear-all (wins over a write) and a flat read bus.
module matrix_slot_bank
    import matrix_input_collector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_wr_en,
    input  logic [SLOT_W-1:0]           i_wr_addr,
    input  logic [DATA_WIDTH-1:0]       i_wr_data,
    input  logic                        i_clr,
    output logic [SLOTS*DATA_WIDTH-1:0] o_flat
);

    logic [SLOTS*DATA_WIDTH-1:0] r_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flat <= '0;
        end else if (i_clr) begin
            r_flat <= '0;
        end else if (i_wr_en) begin
            r_flat[32'(i_wr_addr)*DATA_WIDTH +: DATA_WIDTH] <= i_wr_data;
        end
    end

    assign o_flat = r_flat;

endmodule

// File: rtl/matrix_input_collector.sv
// Collects an r x c matrix one element per handshake into a fixed stride-5
// image and holds it with a level done flag until cleared.
module matrix_input_collector
    import matrix_input_collector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    matrix_input_collector_if.slave   bus
);

    logic [1:0]        r_state;
    logic [2:0]        r_rows;
    logic [2:0]        r_cols;
    logic [2:0]        r_row;
    logic [2:0]        r_col;
    logic [4:0]        r_cnt;
    logic              r_err_dim;

    logic              w_dims_ok;
    logic              w_accept;
    logic              w_bank_clr;
    logic [SLOT_W-1:0] w_slot;
    logic [4:0]        w_cnt_next;
    logic [4:0]        w_total;

    assign w_dims_ok  = dim_ok(bus.dim_r) && dim_ok(bus.dim_c);
    // abort masks the accept so an element on the abort edge is never written
    assign w_accept   = (r_state == ST_LOAD) && bus.elem_valid && !bus.abort;
    assign w_bank_clr = ((r_state == ST_IDLE) && bus.start && w_dims_ok) ||
                        ((r_state == ST_LOAD) && bus.abort);
    assign w_slot     = {r_row, 2'b00} + {2'b00, r_row} + {2'b00, r_col};
    assign w_cnt_next = r_cnt + 5'd1;
    assign w_total    = {2'b00, r_rows} * {2'b00, r_cols};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rows    <= '0;
            r_cols    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_err_dim <= 1'b0;
        end else begin
            r_err_dim <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_dims_ok) begin
                            r_rows  <= bus.dim_r;
                            r_cols  <= bus.dim_c;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_err_dim <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end else if (w_accept) begin
                        r_cnt <= w_cnt_next;
                        if (r_col == r_cols - 3'd1) begin
                            r_col <= '0;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                        if (w_cnt_next == w_total) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.clear) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    matrix_slot_bank #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_accept),
        .i_wr_addr (w_slot),
        .i_wr_data (bus.elem_data),
        .i_clr     (w_bank_clr),
        .o_flat    (bus.mat_flat)
    );

    assign bus.elem_ready = (r_state == ST_LOAD);
    assign bus.busy       = (r_state == ST_LOAD);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err_dim    = r_err_dim;
    assign bus.r_out      = r_rows;
    assign bus.c_out      = r_cols;
    assign bus.elem_cnt   = r_cnt;

endmodule

// File: tb/tb_matrix_input_collector.sv
// Scoreboard bench for matrix_input_collector: elements are queued with their
// target slot as they are driven and checked against the frozen image.
module tb_matrix_input_collector;

    localparam int unsigned DW = 9;
    localparam int unsigned FW = 25 * DW;

    typedef struct {
        int unsigned   slot;
        logic [DW-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    logic [FW-1:0] held_img;

    always #5 clk = ~clk;

    matrix_input_collector_if #(.DATA_WIDTH(DW)) bus ();

    matrix_input_collector #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [FW-1:0] pop_expected();
        logic [FW-1:0] img = '0;
        while (sb_q.size() > 0) begin
            exp_t e = sb_q.pop_front();
            img[e.slot*DW +: DW] = e.val;
        end
        return img;
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.dim_r = '0; bus.dim_c = '0;
        bus.elem_valid = 1'b0; bus.elem_data = '0;
        bus.abort = 1'b0; bus.clear = 1'b0;
    endtask

    // Drives start for one cycle; returns at the negedge after it was sampled.
    task automatic do_start(input logic [2:0] r, input logic [2:0] c);
        @(negedge clk);
        bus.start = 1'b1; bus.dim_r = r; bus.dim_c = c;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Streams r*c elements back-to-back starting at base, queueing slot/value.
    task automatic stream(input int unsigned r, input int unsigned c, input int unsigned base);
        for (int unsigned i = 0; i < r * c; i++) begin
            bus.elem_valid = 1'b1;
            bus.elem_data  = DW'(base + i);
            sb_q.push_back('{slot: (i / c) * 5 + (i % c), val: DW'(base + i)});
            @(negedge clk);
        end
        bus.elem_valid = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({bus.elem_ready, bus.busy, bus.done, bus.err_dim} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {bus.elem_ready, bus.busy, bus.done, bus.err_dim});
        end
        n_checks++;
        if ({bus.r_out, bus.c_out, bus.elem_cnt} !== 11'd0) begin
            n_fail++; $display("FAIL reset_counts: got %h expected 0", {bus.r_out, bus.c_out, bus.elem_cnt});
        end
        n_checks++;
        if (bus.mat_flat !== '0) begin
            n_fail++; $display("FAIL reset_mat: got %h expected 0", bus.mat_flat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_2x3();
        logic [FW-1:0] exp_img;
        do_start(3'd2, 3'd3);
        n_checks++;
        if ({bus.busy, bus.elem_ready, bus.done} !== 3'b110) begin
            n_fail++; $display("FAIL load_entry: got %b expected 110", {bus.busy, bus.elem_ready, bus.done});
        end
        for (int unsigned i = 0; i < 6; i++) begin
            bus.elem_valid = 1'b1;
            bus.elem_data  = DW'(i + 1);
            sb_q.push_back('{slot: (i / 3) * 5 + (i % 3), val: DW'(i + 1)});
            @(negedge clk);
            n_checks++;
            if (bus.done !== (i == 5) || bus.elem_cnt !== 5'(i + 1)) begin
                n_fail++; $display("FAIL 2x3_progress[%0d]: got done=%b cnt=%0d expected done=%b cnt=%0d",
                                   i, bus.done, bus.elem_cnt, (i == 5), i + 1);
            end
        end
        bus.elem_valid = 1'b0;
        exp_img = pop_expected();
        n_checks++;
        if (bus.mat_flat !== exp_img) begin
            n_fail++; $display("FAIL 2x3_image: got %h expected %h", bus.mat_flat, exp_img);
        end
        n_checks++;
        if ({bus.r_out, bus.c_out, bus.elem_ready, bus.busy} !== {3'd2, 3'd3, 2'b00}) begin
            n_fail++; $display("FAIL 2x3_dims: got r=%0d c=%0d rdy=%b busy=%b expected 2 3 0 0",
                               bus.r_out, bus.c_out, bus.elem_ready, bus.busy);
        end
        do_clear();
    endtask

    task automatic test_5x5_gap();
        do_start(3'd5, 3'd5);
        for (int unsigned k = 0; k < 25; k++) begin
            bus.elem_valid = 1'b1;
            bus.elem_data  = DW'(k);
            sb_q.push_back('{slot: k, val: DW'(k)});
            @(negedge clk);
            if (k == 10) begin
                bus.elem_valid = 1'b0;
                bus.elem_data  = 9'h1AA;
                for (int unsigned g = 0; g < 3; g++) begin
                    @(negedge clk);
                    n_checks++;
                    if ({bus.elem_ready, bus.done} !== 2'b10 || bus.elem_cnt !== 5'd11) begin
                        n_fail++; $display("FAIL 5x5_gap[%0d]: got rdy=%b done=%b cnt=%0d expected 1 0 11",
                                           g, bus.elem_ready, bus.done, bus.elem_cnt);
                    end
                end
            end else if (k == 23) begin
                n_checks++;
                if (bus.done !== 1'b0) begin
                    n_fail++; $display("FAIL 5x5_early_done: got %b expected 0", bus.done);
                end
            end
        end
        bus.elem_valid = 1'b0;
        held_img = pop_expected();
        n_checks++;
        if (bus.done !== 1'b1 || bus.elem_cnt !== 5'd25) begin
            n_fail++; $display("FAIL 5x5_done: got done=%b cnt=%0d expected 1 25", bus.done, bus.elem_cnt);
        end
        n_checks++;
        if (bus.mat_flat !== held_img) begin
            n_fail++; $display("FAIL 5x5_image: got %h expected %h", bus.mat_flat, held_img);
        end
        do_clear();
    endtask

    task automatic test_bad_dims();
        logic [2:0] rs [2] = '{3'd0, 3'd6};
        logic [2:0] cs [2] = '{3'd3, 3'd2};
        for (int i = 0; i < 2; i++) begin
            do_start(rs[i], cs[i]);
            n_checks++;
            if ({bus.err_dim, bus.busy, bus.elem_ready} !== 3'b100) begin
                n_fail++; $display("FAIL bad_dims_pulse[%0d]: got err/busy/rdy=%b expected 100",
                                   i, {bus.err_dim, bus.busy, bus.elem_ready});
            end
            @(negedge clk);
            n_checks++;
            if (bus.err_dim !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL bad_dims_width[%0d]: got err=%b busy=%b expected 0 0",
                                   i, bus.err_dim, bus.busy);
            end
            n_checks++;
            if (bus.r_out !== 3'd5 || bus.c_out !== 3'd5 || bus.mat_flat !== held_img) begin
                n_fail++; $display("FAIL bad_dims_hold[%0d]: got r=%0d c=%0d mat=%h expected 5 5 %h",
                                   i, bus.r_out, bus.c_out, bus.mat_flat, held_img);
            end
        end
    endtask

    task automatic test_abort();
        do_start(3'd3, 3'd3);
        for (int unsigned i = 0; i < 4; i++) begin
            bus.elem_valid = 1'b1;
            bus.elem_data  = DW'(20 + i);
            @(negedge clk);
        end
        bus.elem_data = 9'd99;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.abort      = 1'b0;
        bus.elem_valid = 1'b0;
        n_checks++;
        if ({bus.busy, bus.elem_ready, bus.done} !== 3'b000 || bus.elem_cnt !== 5'd0) begin
            n_fail++; $display("FAIL abort_state: got b/r/d=%b cnt=%0d expected 000 0",
                               {bus.busy, bus.elem_ready, bus.done}, bus.elem_cnt);
        end
        n_checks++;
        if (bus.mat_flat !== '0) begin
            n_fail++; $display("FAIL abort_mat: got %h expected 0", bus.mat_flat);
        end
        sb_q.delete();
    endtask

    task automatic test_done_hold();
        logic [FW-1:0] exp_img;
        do_start(3'd2, 3'd2);
        stream(2, 2, 40);
        exp_img = pop_expected();
        bus.elem_valid = 1'b1; bus.elem_data = 9'h1FF;
        bus.start = 1'b1; bus.dim_r = 3'd1; bus.dim_c = 3'd1;
        repeat (2) @(negedge clk);
        bus.elem_valid = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.mat_flat !== exp_img || bus.elem_cnt !== 5'd4) begin
            n_fail++; $display("FAIL done_hold: got done=%b cnt=%0d mat=%h expected 1 4 %h",
                               bus.done, bus.elem_cnt, bus.mat_flat, exp_img);
        end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0; bus.start = 1'b0;
        n_checks++;
        if ({bus.done, bus.busy} !== 2'b00 || bus.mat_flat !== exp_img || bus.r_out !== 3'd2) begin
            n_fail++; $display("FAIL clear_retain: got d/b=%b r=%0d mat=%h expected 00 2 %h",
                               {bus.done, bus.busy}, bus.r_out, bus.mat_flat, exp_img);
        end
        do_start(3'd1, 3'd1);
        stream(1, 1, 7);
        exp_img = pop_expected();
        n_checks++;
        if (bus.done !== 1'b1 || bus.mat_flat !== exp_img) begin
            n_fail++; $display("FAIL 1x1_image: got done=%b mat=%h expected 1 %h", bus.done, bus.mat_flat, exp_img);
        end
        do_clear();
    endtask

    task automatic test_async_reset();
        do_start(3'd3, 3'd3);
        bus.elem_valid = 1'b1; bus.elem_data = 9'h055;
        @(negedge clk);
        @(negedge clk);
        bus.elem_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.elem_ready, bus.busy, bus.done, bus.err_dim} !== 4'b0 ||
            {bus.r_out, bus.c_out, bus.elem_cnt} !== 11'd0 || bus.mat_flat !== '0) begin
            n_fail++; $display("FAIL async_reset: got flags=%b cnt=%0d mat=%h expected all 0",
                               {bus.elem_ready, bus.busy, bus.done, bus.err_dim}, bus.elem_cnt, bus.mat_flat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_2x3();
        test_5x5_gap();
        test_bad_dims();
        test_abort();
        test_done_hold();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
